// File: rtl/preg_free_list_pkg.sv
// Shared physical-register constants and types for rename, ROB and the free list.
// Imported by every block that handles physical tags.
package preg_free_list_pkg;

    localparam int PREG_WIDTH = 6;
    localparam int AREG_WIDTH = 5;
    localparam int NUM_PREG   = 64;
    localparam int NUM_AREG   = 32;
    localparam int DEPTH      = NUM_PREG - NUM_AREG;
    localparam int PTR_W      = $clog2(DEPTH) + 1;

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [PTR_W-1:0]      ptr_t;

    localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_free_list_circ_ptr.sv
// Circular-queue pointer with wrap bit in the MSB.
// Load has priority over increment.
module preg_free_list_circ_ptr
    import preg_free_list_pkg::*;
#(
    parameter ptr_t RST_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t ptr
);

    ptr_t ptr_q;
    ptr_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= RST_VAL;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: circular queue of free tags, one grant
// and one release per cycle, single head checkpoint for mispredict recovery.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [PREG_WIDTH-1:0] alloc_preg,
    input  logic                  rel_valid,
    input  logic [PREG_WIDTH-1:0] rel_preg,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore,
    output logic                  stall,
    output logic [PREG_WIDTH-1:0] free_count,
    output logic                  rel_err
);

    localparam ptr_t TAIL_RST = ptr_t'(DEPTH);

    preg_t mem_q [DEPTH];
    preg_t mem_d [DEPTH];

    ptr_t head;
    ptr_t tail;
    ptr_t count;
    ptr_t saved_head_q;
    ptr_t saved_head_d;
    logic rel_err_q;
    logic rel_err_d;

    logic empty;
    logic full;
    logic rel_ok;
    logic rel_bad;

    assign count = tail - head;
    assign empty = (count == '0);
    assign full  = (count == ptr_t'(DEPTH));

    assign alloc_gnt  = alloc_req & ~empty & ~ckpt_restore;
    assign stall      = alloc_req & empty & ~ckpt_restore;
    assign alloc_preg = mem_q[head[PTR_W-2:0]];

    // x0 is hard-wired and never enters the queue.
    assign rel_ok  = rel_valid & ~full & (rel_preg != PREG_ZERO);
    assign rel_bad = rel_valid & (full | (rel_preg == PREG_ZERO));

    preg_free_list_circ_ptr #(
        .RST_VAL ('0)
    ) u_head (
        .clk      (clk),
        .rst      (rst),
        .inc      (alloc_gnt),
        .load     (ckpt_restore),
        .load_val (saved_head_q),
        .ptr      (head)
    );

    preg_free_list_circ_ptr #(
        .RST_VAL (TAIL_RST)
    ) u_tail (
        .clk      (clk),
        .rst      (rst),
        .inc      (rel_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail)
    );

    always_comb begin
        mem_d = mem_q;
        if (rel_ok) begin
            mem_d[tail[PTR_W-2:0]] = rel_preg;
        end
    end

    always_comb begin
        saved_head_d = saved_head_q;
        if (ckpt_save && !ckpt_restore) begin
            saved_head_d = head + ptr_t'(alloc_gnt);
        end
    end

    assign rel_err_d = rel_err_q | rel_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= preg_t'(NUM_AREG + i);
            end
            saved_head_q <= '0;
            rel_err_q    <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            saved_head_q <= saved_head_d;
            rel_err_q    <= rel_err_d;
        end
    end

    assign free_count = PREG_WIDTH'(count);
    assign rel_err    = rel_err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: grants, stall, release errors,
// checkpoint recovery and sustained FIFO recycling.
module tb_preg_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [5:0] alloc_preg;
    logic       rel_valid;
    logic [5:0] rel_preg;
    logic       ckpt_save;
    logic       ckpt_restore;
    logic       stall;
    logic [5:0] free_count;
    logic       rel_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    preg_free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_preg   (alloc_preg),
        .rel_valid    (rel_valid),
        .rel_preg     (rel_preg),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .stall        (stall),
        .free_count   (free_count),
        .rel_err      (rel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic idle();
        alloc_req    = 1'b0;
        rel_valid    = 1'b0;
        rel_preg     = 6'd0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input string tag, input int exp_tag);
        idle();
        alloc_req = 1'b1;
        #1;
        chk({tag, "_gnt"}, alloc_gnt, 1);
        chk({tag, "_preg"}, alloc_preg, exp_tag);
        tick();
        idle();
    endtask

    int q[$];
    int exp_tag;
    int rtag;

    initial begin
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_free", free_count, 32);
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", rel_err, 0);

        // 1: drain all 32 tags in order
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("drain_gnt", alloc_gnt, 1);
            chk("drain_preg", alloc_preg, 32 + i);
            chk("drain_stall", stall, 0);
            tick();
        end
        #1;
        chk("empty_gnt", alloc_gnt, 0);
        chk("empty_stall", stall, 1);
        chk("empty_free", free_count, 0);

        // 2: no bypass of a same-cycle release
        rel_valid = 1'b1;
        rel_preg  = 6'd5;
        #1;
        chk("nobyp_gnt", alloc_gnt, 0);
        chk("nobyp_stall", stall, 1);
        tick();
        rel_valid = 1'b0;
        #1;
        chk("nobyp_free", free_count, 1);
        chk("nobyp_gnt2", alloc_gnt, 1);
        chk("nobyp_preg2", alloc_preg, 5);
        chk("nobyp_stall2", stall, 0);
        tick();
        idle();
        #1;
        chk("nobyp_free2", free_count, 0);

        // 3: release while full, then release of x0
        do_reset();
        rel_valid = 1'b1;
        rel_preg  = 6'd40;
        tick();
        idle();
        chk("full_err", rel_err, 1);
        chk("full_free", free_count, 32);
        do_reset();
        chk("err_clr", rel_err, 0);
        alloc_one("x0pre", 32);
        chk("x0_free0", free_count, 31);
        rel_valid = 1'b1;
        rel_preg  = 6'd0;
        tick();
        idle();
        chk("x0_err", rel_err, 1);
        chk("x0_free", free_count, 31);

        // 4: checkpoint, speculative allocs, release, restore
        do_reset();
        alloc_one("ck_a0", 32);
        alloc_one("ck_a1", 33);
        ckpt_save = 1'b1;
        tick();
        idle();
        alloc_one("ck_a2", 34);
        alloc_one("ck_a3", 35);
        rel_valid = 1'b1;
        rel_preg  = 6'd10;
        tick();
        idle();
        chk("ck_free_pre", free_count, 29);
        ckpt_restore = 1'b1;
        tick();
        idle();
        chk("ck_free", free_count, 31);
        alloc_one("ck_after", 34);

        // 5: restore with alloc_req suppresses the grant
        do_reset();
        alloc_one("r5_a0", 32);
        alloc_req = 1'b1;
        ckpt_save = 1'b1;
        #1;
        chk("r5_savegnt", alloc_gnt, 1);
        chk("r5_savepreg", alloc_preg, 33);
        tick();
        idle();
        alloc_one("r5_a2", 34);
        alloc_req    = 1'b1;
        ckpt_restore = 1'b1;
        #1;
        chk("r5_gnt", alloc_gnt, 0);
        chk("r5_stall", stall, 0);
        tick();
        idle();
        #1;
        chk("r5_free", free_count, 30);
        chk("r5_head", alloc_preg, 34);

        // 6: sustained alloc+release over several wraps
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one("s6_pre", 32 + i);
        q.delete();
        for (int t = 36; t < 64; t++) q.push_back(t);
        for (int i = 0; i < 100; i++) begin
            rtag = ((i * 7) % 63) + 1;
            alloc_req = 1'b1;
            rel_valid = 1'b1;
            rel_preg  = 6'(rtag);
            #1;
            exp_tag = q.pop_front();
            q.push_back(rtag);
            chk("s6_gnt", alloc_gnt, 1);
            chk("s6_preg", alloc_preg, exp_tag);
            tick();
            chk("s6_free", free_count, 28);
        end
        idle();
        chk("s6_err", rel_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
